// File: rtl/modulo_product_w.sv
// Bit-serial modular multiplier: o_result = (a * b) mod n.
// Optional MODPROD_EARLY_TERM_EN ends S_CALC once the remaining multiplier bits are zero.
module modulo_product_w #(
    parameter int W = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_a,
    input  logic [W:0]   i_b,
    output logic [W-1:0] o_result,
    output logic         o_busy,
    output logic         o_finish,
    output logic         o_err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  a_q, a_d;
    logic [W:0]    b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  mult_q, mult_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [W:0]    n_ext;
    logic [W:0]    t, t_sub;
    logic [W:0]    s, s_sub;
    logic [W:0]    m2, m2_sub;
    logic [W-1:0]  t_red, s_red, m2_red;

    // Every operand below is already < n, so one conditional subtract reduces it.
    assign n_ext  = {1'b0, n_q};
    assign t      = {r_q, b_q[W]};
    assign t_sub  = t - n_ext;
    assign t_red  = (t >= n_ext) ? t_sub[W-1:0] : t[W-1:0];
    assign s      = {1'b0, acc_q} + {1'b0, mult_q};
    assign s_sub  = s - n_ext;
    assign s_red  = (s >= n_ext) ? s_sub[W-1:0] : s[W-1:0];
    assign m2     = {mult_q, 1'b0};
    assign m2_sub = m2 - n_ext;
    assign m2_red = (m2 >= n_ext) ? m2_sub[W-1:0] : m2[W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d   = i_n;
                    a_d   = i_a;
                    b_d   = i_b;
                    err_d = 1'b0;
                    if (i_n == '0) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        r_d     = '0;
                        cnt_d   = CW'(W);
                        state_d = S_PREP;
                    end
                end
            end

            // b is consumed MSB first from the top of a left-shift register.
            S_PREP: begin
                r_d   = t_red;
                b_d   = b_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    mult_d  = t_red;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
`ifdef MODPROD_EARLY_TERM_EN
                if (a_q == '0) begin
                    res_d   = acc_q;
                    state_d = S_DONE;
                end else begin
                    if (a_q[0])
                        acc_d = s_red;
                    mult_d = m2_red;
                    a_d    = a_q >> 1;
                end
`else
                if (a_q[0])
                    acc_d = s_red;
                mult_d = m2_red;
                a_d    = a_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_d   = a_q[0] ? s_red : acc_q;
                    state_d = S_DONE;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_result = res_q;
    assign o_err    = err_q;
    assign o_finish = (state_q == S_DONE);
    assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_modulo_product_w.sv
// Testbench for modulo_product_w: W=8 and W=256 instances checked
// against a plain-arithmetic (a*b) mod n model and a latency model.
module tb_modulo_product_w;

    logic clk = 1'b0;
    logic rst_n;

    logic         s8;
    logic [7:0]   n8, a8;
    logic [8:0]   b8;
    logic [7:0]   r8;
    logic         busy8, fin8, err8;

    logic         sw;
    logic [255:0] nw, aw;
    logic [256:0] bw;
    logic [255:0] rw;
    logic         busyw, finw, errw;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    modulo_product_w #(.W(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8),
        .i_n(n8), .i_a(a8), .i_b(b8),
        .o_result(r8), .o_busy(busy8), .o_finish(fin8), .o_err(err8)
    );

    modulo_product_w #(.W(256)) u_dutw (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(sw),
        .i_n(nw), .i_a(aw), .i_b(bw),
        .o_result(rw), .o_busy(busyw), .o_finish(finw), .o_err(errw)
    );

    function automatic logic [7:0] ref8(int n, int a, int b);
        longint p;
        p = (longint'(a) * longint'(b)) % longint'(n);
        return p[7:0];
    endfunction

    function automatic logic [255:0] refw(logic [255:0] n, logic [255:0] a,
                                          logic [256:0] b);
        logic [767:0] p;
        p = {512'b0, a} * {511'b0, b};
        p = p % {512'b0, n};
        return p[255:0];
    endfunction

    function automatic int exp_lat(int w, logic [255:0] n, logic [255:0] a);
        int msb;
        int calc;
        if (n == '0)
            return 1;
        msb = -1;
        for (int i = 0; i < w; i++)
            if (a[i]) msb = i;
        calc = w;
`ifdef MODPROD_EARLY_TERM_EN
        calc = (msb < 0) ? 1 : msb + 2;
`endif
        return w + 1 + calc + 1;
    endfunction

    task automatic run8(input int n, input int a, input int b,
                        output logic [7:0] res, output int lat,
                        output logic err, output logic busy_ok,
                        output logic single);
        @(posedge clk); #1;
        n8 = 8'(n); a8 = 8'(a); b8 = 9'(b); s8 = 1'b1;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) s8 = 1'b0;
            if (!busy8) busy_ok = 1'b0;
            if (fin8) begin
                lat = k;
                break;
            end
        end
        res = r8;
        err = err8;
        @(posedge clk); #1;
        single = !fin8 && !busy8;
    endtask

    task automatic runw(input logic [255:0] n, input logic [255:0] a,
                        input logic [256:0] b, output logic [255:0] res,
                        output int lat, output logic err);
        @(posedge clk); #1;
        nw = n; aw = a; bw = b; sw = 1'b1;
        lat = 0;
        for (int k = 1; k <= 1200; k++) begin
            @(posedge clk); #1;
            if (k == 1) sw = 1'b0;
            if (finw) begin
                lat = k;
                break;
            end
        end
        res = rw;
        err = errw;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
        sw = 1'b0; nw = '0; aw = '0; bw = '0;
        #12;
        n_cmp++;
        if ({r8, busy8, fin8, err8} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset8: got r=%0d busy=%b fin=%b err=%b, want all 0",
                     r8, busy8, fin8, err8);
        end
        n_cmp++;
        if (rw !== '0 || busyw !== 1'b0 || finw !== 1'b0 || errw !== 1'b0) begin
            n_bad++;
            $display("FAIL resetw: got busy=%b fin=%b err=%b, want all 0",
                     busyw, finw, errw);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] res;
        int lat;
        logic err, bok, sgl;
        int el;
        el = exp_lat(8, 256'd13, 256'd7);
        run8(13, 7, 20, res, lat, err, bok, sgl);
        n_cmp++;
        if (res !== 8'd10) begin
            n_bad++; $display("FAIL basic_res: got %0d want 10", res);
        end
        n_cmp++;
        if (lat !== el) begin
            n_bad++; $display("FAIL basic_lat: got %0d want %0d", lat, el);
        end
        n_cmp++;
        if (err !== 1'b0 || bok !== 1'b1 || sgl !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_flags: got err=%b busy=%b single=%b want 0 1 1",
                     err, bok, sgl);
        end
        run8(251, 255, 511, res, lat, err, bok, sgl);
        n_cmp++;
        if (res !== 8'd36) begin
            n_bad++; $display("FAIL n251_res: got %0d want 36", res);
        end
        run8(1, 200, 300, res, lat, err, bok, sgl);
        n_cmp++;
        if (res !== 8'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL n1: got res=%0d err=%b want 0 0", res, err);
        end
    endtask

    task automatic test_random;
        logic [7:0] res;
        int lat;
        logic err, bok, sgl;
        int n, a, b;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(1, 255);
            a = (i == 0) ? 0 : $urandom_range(0, 255);
            b = (i == 1) ? 256 : $urandom_range(0, 511);
            run8(n, a, b, res, lat, err, bok, sgl);
            n_cmp++;
            if (res !== ref8(n, a, b) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_res n=%0d a=%0d b=%0d: got %0d err=%b want %0d",
                         n, a, b, res, err, ref8(n, a, b));
            end
            n_cmp++;
            if (lat !== exp_lat(8, 256'(n), 256'(a)) || !bok || !sgl) begin
                n_bad++;
                $display("FAIL rand_lat a=%0d: got %0d busy=%b single=%b want %0d",
                         a, lat, bok, sgl, exp_lat(8, 256'(n), 256'(a)));
            end
        end
    endtask

    task automatic test_error;
        logic [7:0] res;
        int lat;
        logic err, bok, sgl;
        run8(0, 3, 4, res, lat, err, bok, sgl);
        n_cmp++;
        if (lat !== 1 || err !== 1'b1 || res !== 8'd0) begin
            n_bad++;
            $display("FAIL nzero: got lat=%0d err=%b res=%0d want 1 1 0",
                     lat, err, res);
        end
        run8(13, 7, 20, res, lat, err, bok, sgl);
        n_cmp++;
        if (err !== 1'b0 || res !== 8'd10) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b res=%0d want 0 10", err, res);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        int el;
        el = exp_lat(8, 256'd13, 256'd7);
        lat = 0;
        @(posedge clk); #1;
        n8 = 8'd13; a8 = 8'd7; b8 = 9'd20; s8 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                s8 = 1'b0; n8 = 8'd200; a8 = 8'd99; b8 = 9'd77;
            end
            if (k == 5) s8 = 1'b1;
            if (k == 6) s8 = 1'b0;
            if (fin8) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat !== el || r8 !== 8'd10) begin
            n_bad++;
            $display("FAIL ignore_start: got lat=%0d res=%0d want %0d 10",
                     lat, r8, el);
        end
    endtask

    task automatic test_midreset;
        logic seen;
        @(posedge clk); #1;
        n8 = 8'd13; a8 = 8'd7; b8 = 9'd20; s8 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) s8 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({r8, busy8, fin8, err8} !== 11'b0) begin
            n_bad++;
            $display("FAIL midreset: got r=%0d busy=%b fin=%b err=%b want all 0",
                     r8, busy8, fin8, err8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (fin8 || busy8) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL midreset_nofinish: got activity=1 want 0");
        end
    endtask

    task automatic test_back_to_back;
        int f1, f2;
        logic [7:0] r1, r2;
        int e1, e2;
        e1 = exp_lat(8, 256'd13, 256'd7);
        e2 = e1 + 1 + exp_lat(8, 256'd251, 256'd255);
        f1 = 0; f2 = 0; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        n8 = 8'd13; a8 = 8'd7; b8 = 9'd20; s8 = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                n8 = 8'd251; a8 = 8'd255; b8 = 9'd511;
            end
            if (fin8) begin
                if (f1 == 0) begin
                    f1 = k; r1 = r8;
                end else begin
                    f2 = k; r2 = r8; s8 = 1'b0;
                    break;
                end
            end
        end
        s8 = 1'b0;
        n_cmp++;
        if (f1 !== e1 || r1 !== 8'd10) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d res=%0d want %0d 10", f1, r1, e1);
        end
        n_cmp++;
        if (f2 !== e2 || r2 !== 8'd36) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d res=%0d want %0d 36", f2, r2, e2);
        end
    endtask

    task automatic test_wide;
        logic [255:0] res, n, a, exp;
        logic [256:0] b;
        int lat;
        logic err;
        n = '1;
        a = 256'd5;
        b = 257'b1 << 256;
        runw(n, a, b, res, lat, err);
        n_cmp++;
        if (res !== 256'd5 || err !== 1'b0) begin
            n_bad++; $display("FAIL wide_5: got %h err=%b want 5", res, err);
        end
        n_cmp++;
        if (lat !== exp_lat(256, n, a)) begin
            n_bad++;
            $display("FAIL wide_lat: got %0d want %0d", lat, exp_lat(256, n, a));
        end
        n = (256'b1 << 255) + 256'd1;
        a = 256'd2;
        exp = (256'b1 << 255) - 256'd3;
        runw(n, a, b, res, lat, err);
        n_cmp++;
        if (res !== exp) begin
            n_bad++; $display("FAIL wide_half: got %h want %h", res, exp);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 8; j++) begin
                n[j*32 +: 32] = $urandom;
                a[j*32 +: 32] = $urandom;
                b[j*32 +: 32] = $urandom;
            end
            b[256] = 1'($urandom_range(0, 1));
            n[255] = 1'b1;
            exp = refw(n, a, b);
            runw(n, a, b, res, lat, err);
            n_cmp++;
            if (res !== exp || lat !== exp_lat(256, n, a)) begin
                n_bad++;
                $display("FAIL wide_rand%0d: got %h lat=%0d want %h lat=%0d",
                         i, res, lat, exp, exp_lat(256, n, a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_wide();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
